carus_clk_gate_ctrl: RTL and testbench

CARUS_CLK_GATE_CTRL -- requirements
Module: carus_clk_gate_ctrl

---
 rtl/carus_cg_pkg.sv | 24 ++
 rtl/carus_clk_gate_ctrl.sv | 119 +++++++++++
 tb/tb_carus_clk_gate_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/carus_cg_pkg.sv
// Shared types and constants for the Carus clock-gate controller.
// Holds the FSM state encoding, counter widths and a saturating increment helper.
package carus_cg_pkg;

    localparam int CARUS_CG_CNT_W  = 8;
    localparam int CARUS_CG_GATE_W = 16;

    typedef enum logic [1:0] {
        CG_RUN  = 2'd0,
        CG_IDLE = 2'd1,
        CG_OFF  = 2'd2,
        CG_WAKE = 2'd3
    } carus_cg_state_e;

    function automatic logic [CARUS_CG_GATE_W-1:0] carus_cg_sat_inc(
        input logic [CARUS_CG_GATE_W-1:0] val
    );
        if (&val) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/carus_clk_gate_ctrl.sv
// Idle-driven clock-gate controller for Carus: gates the clock after a quiet window
// and ungates it with a settle phase before signalling ready.
module carus_clk_gate_ctrl
    import carus_cg_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cg_enable_i,
    input  logic                       busy_i,
    input  logic                       req_i,
    output logic                       ready_o,
    output logic                       clk_en_o,
    output logic                       gated_o,
    output logic [CARUS_CG_GATE_W-1:0] gate_cnt_o
);

    if (IDLE_CYCLES == 0 || IDLE_CYCLES > 255) begin : g_bad_idle
        $error("carus_clk_gate_ctrl: IDLE_CYCLES=%0d outside 1..255", IDLE_CYCLES);
    end
    if (WAKE_CYCLES == 0 || WAKE_CYCLES > 255) begin : g_bad_wake
        $error("carus_clk_gate_ctrl: WAKE_CYCLES=%0d outside 1..255", WAKE_CYCLES);
    end

    localparam logic [CARUS_CG_CNT_W-1:0] IDLE_LOAD = CARUS_CG_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CARUS_CG_CNT_W-1:0] WAKE_LOAD = CARUS_CG_CNT_W'(WAKE_CYCLES - 1);

    carus_cg_state_e             state_q, state_d;
    logic [CARUS_CG_CNT_W-1:0]   cnt_q, cnt_d;
    logic [CARUS_CG_GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic                        activity;

    // Disabling gating is treated as permanent activity so the clock never stops.
    assign activity = busy_i | req_i | ~cg_enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CG_RUN;
            cnt_q      <= '0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gate_cnt_d = gate_cnt_q;
        case (state_q)
            CG_RUN: begin
                if (!activity) begin
                    state_d = CG_IDLE;
                    cnt_d   = IDLE_LOAD;
                end
            end
            CG_IDLE: begin
                // Activity wins over expiry so a late request never sees the clock stop.
                if (activity) begin
                    state_d = CG_RUN;
                end else if (cnt_q == '0) begin
                    state_d    = CG_OFF;
                    gate_cnt_d = carus_cg_sat_inc(gate_cnt_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CG_OFF: begin
                if (activity) begin
                    state_d = CG_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            CG_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = CG_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CG_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clk_en_o = 1'b1;
        ready_o  = 1'b1;
        gated_o  = 1'b0;
        case (state_q)
            CG_RUN, CG_IDLE: begin
                clk_en_o = 1'b1;
                ready_o  = 1'b1;
            end
            CG_OFF: begin
                clk_en_o = 1'b0;
                ready_o  = 1'b0;
                gated_o  = 1'b1;
            end
            CG_WAKE: begin
                clk_en_o = 1'b1;
                ready_o  = 1'b0;
            end
            default: begin
                clk_en_o = 1'b1;
                ready_o  = 1'b1;
            end
        endcase
    end

    assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_carus_clk_gate_ctrl.sv
// Bench for carus_clk_gate_ctrl: vector table and saturation on a short-window
// instance, directed latency sequences and random traffic on a default instance.
module tb_carus_clk_gate_ctrl;

    localparam int M_IDLE = 16;
    localparam int M_WAKE = 2;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic m_rst, m_en, m_busy, m_req;
    logic m_ready, m_clk_en, m_gated;
    logic [15:0] m_gcnt;

    carus_clk_gate_ctrl #(.IDLE_CYCLES(M_IDLE), .WAKE_CYCLES(M_WAKE)) dut (
        .clk_i(clk), .rst_i(m_rst), .cg_enable_i(m_en), .busy_i(m_busy), .req_i(m_req),
        .ready_o(m_ready), .clk_en_o(m_clk_en), .gated_o(m_gated), .gate_cnt_o(m_gcnt)
    );

    // short-window instance
    logic s_rst, s_en, s_busy, s_req;
    logic s_ready, s_clk_en, s_gated;
    logic [15:0] s_gcnt;

    carus_clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(2)) dut_s (
        .clk_i(clk), .rst_i(s_rst), .cg_enable_i(s_en), .busy_i(s_busy), .req_i(s_req),
        .ready_o(s_ready), .clk_en_o(s_clk_en), .gated_o(s_gated), .gate_cnt_o(s_gcnt)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive quiet cycles, gates after IDLE+1 of them,
    // then holds the clock unready for WAKE cycles after activity returns.
    int quiet_len, wake_rem, gcnt_ref;
    bit off_ref;

    task automatic model_edge(input logic rst, input logic en, input logic busy, input logic req);
        bit act;
        act = busy | req | ~en;
        if (rst) begin
            quiet_len = 0; wake_rem = 0; gcnt_ref = 0; off_ref = 0;
        end else if (off_ref) begin
            if (act) begin
                off_ref  = 0;
                wake_rem = M_WAKE;
            end
        end else if (wake_rem > 0) begin
            wake_rem--;
        end else if (act) begin
            quiet_len = 0;
        end else begin
            quiet_len++;
            if (quiet_len == M_IDLE + 1) begin
                off_ref   = 1;
                quiet_len = 0;
                if (gcnt_ref < 65535) gcnt_ref++;
            end
        end
    endtask

    task automatic step_main(input string tag);
        @(posedge clk);
        model_edge(m_rst, m_en, m_busy, m_req);
        #1;
        chk({tag, ".clk_en"}, 32'(m_clk_en), 32'(!off_ref));
        chk({tag, ".ready"},  32'(m_ready),  32'(!off_ref && wake_rem == 0));
        chk({tag, ".gated"},  32'(m_gated),  32'(off_ref));
        chk({tag, ".gcnt"},   32'(m_gcnt),   32'(gcnt_ref));
    endtask

    task automatic step_s();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic rst, en, busy, req;
        logic ce, rdy, gt;
        logic [15:0] gc;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int bad;
        quiet_len = 0; wake_rem = 0; gcnt_ref = 0; off_ref = 0;
        m_rst = 1; m_en = 1; m_busy = 0; m_req = 0;
        s_rst = 1; s_en = 1; s_busy = 0; s_req = 0;

        // rst en busy req | clk_en ready gated gate_cnt   (IDLE=1, WAKE=2)
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            s_rst = tbl[i].rst; s_en = tbl[i].en; s_busy = tbl[i].busy; s_req = tbl[i].req;
            step_s();
            chk($sformatf("tbl%0d.clk_en", i), 32'(s_clk_en), 32'(tbl[i].ce));
            chk($sformatf("tbl%0d.ready", i),  32'(s_ready),  32'(tbl[i].rdy));
            chk($sformatf("tbl%0d.gated", i),  32'(s_gated),  32'(tbl[i].gt));
            chk($sformatf("tbl%0d.gcnt", i),   32'(s_gcnt),   32'(tbl[i].gc));
        end

        // saturation: preload the event counter just below full scale
        @(negedge clk);
        force dut_s.gate_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut_s.gate_cnt_q;
        s_en = 1;
        step_s(); step_s();
        chk("sat.first_gate", 32'(s_gcnt), 32'hFFFF);
        chk("sat.gated", 32'(s_gated), 32'd1);
        s_req = 1;
        for (int k = 0; k < 3; k++) step_s();
        s_req = 0;
        step_s(); step_s();
        chk("sat.hold_gated", 32'(s_gated), 32'd1);
        chk("sat.hold_cnt", 32'(s_gcnt), 32'hFFFF);

        // gating latency from reset
        m_rst = 1;
        step_main("reset");
        chk("reset.clk_en", 32'(m_clk_en), 32'd1);
        chk("reset.gcnt", 32'(m_gcnt), 32'd0);
        m_rst = 0; m_en = 1; m_busy = 0; m_req = 0;
        for (int k = 1; k <= 17; k++) begin
            step_main("gate_lat");
            chk($sformatf("gate_lat.c%0d.clk_en", k), 32'(m_clk_en), 32'(k < 17));
        end
        chk("gate_lat.gated", 32'(m_gated), 32'd1);
        chk("gate_lat.gcnt", 32'(m_gcnt), 32'd1);

        // wake latency
        m_req = 1;
        step_main("wake1");
        chk("wake.m1.clk_en", 32'(m_clk_en), 32'd1);
        chk("wake.m1.ready", 32'(m_ready), 32'd0);
        step_main("wake2");
        chk("wake.m2.ready", 32'(m_ready), 32'd0);
        step_main("wake3");
        chk("wake.m3.ready", 32'(m_ready), 32'd1);
        m_req = 0;

        // request arriving exactly at IDLE expiry
        for (int k = 0; k < 16; k++) step_main("idle_fill");
        m_req = 1;
        step_main("idle_exp");
        chk("idle_exp.clk_en", 32'(m_clk_en), 32'd1);
        chk("idle_exp.ready", 32'(m_ready), 32'd1);
        chk("idle_exp.gcnt", 32'(m_gcnt), 32'd1);
        m_req = 0;
        for (int k = 1; k <= 17; k++) begin
            step_main("restart");
            chk($sformatf("restart.c%0d.clk_en", k), 32'(m_clk_en), 32'(k < 17));
        end
        chk("restart.gcnt", 32'(m_gcnt), 32'd2);

        // enable falling while OFF wakes the clock
        m_en = 0;
        step_main("en_wake");
        chk("en_wake.clk_en", 32'(m_clk_en), 32'd1);
        m_en = 1;
        step_main("en_wake2");
        step_main("en_wake3");
        chk("en_wake.ready", 32'(m_ready), 32'd1);

        // reset pulse while OFF
        for (int k = 0; k < 17; k++) step_main("to_off");
        chk("to_off.gated", 32'(m_gated), 32'd1);
        m_rst = 1;
        step_main("rst_off");
        chk("rst_off.clk_en", 32'(m_clk_en), 32'd1);
        chk("rst_off.ready", 32'(m_ready), 32'd1);
        chk("rst_off.gated", 32'(m_gated), 32'd0);
        chk("rst_off.gcnt", 32'(m_gcnt), 32'd0);
        m_rst = 0;

        // gating disabled for a long stretch
        m_en = 0; m_busy = 0; m_req = 0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            model_edge(m_rst, m_en, m_busy, m_req);
            #1;
            if (m_clk_en !== 1'b1) bad++;
        end
        chk("disabled.clk_en_drops", 32'(bad), 32'd0);
        chk("disabled.gcnt", 32'(m_gcnt), 32'd0);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            m_rst  = ($urandom_range(0, 499) == 0);
            m_en   = ($urandom_range(0, 31) != 0);
            m_busy = ($urandom_range(0, 7) == 0);
            m_req  = ($urandom_range(0, 15) == 0);
            step_main("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
